// File: rtl/jedro_1_test_sequencer_if.sv
// Core-side connection of the jedro_1 test sequencer: core reset, halt flag and
// the register-file debug read port. Signal directions are named from the sequencer.
interface jedro_1_test_sequencer_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      core_rstn_o;
    logic [REG_ADDR_WIDTH-1:0] rf_raddr_o;
    logic                      halt_i;
    logic [DATA_WIDTH-1:0]     rf_rdata_i;

    modport master (
        output core_rstn_o,
        output rf_raddr_o,
        input  halt_i,
        input  rf_rdata_i
    );

    modport slave (
        input  core_rstn_o,
        input  rf_raddr_o,
        output halt_i,
        output rf_rdata_i
    );
endinterface

// File: rtl/jedro_1_test_sequencer.sv
// Program-run controller for jedro_1 directed tests: reset, run, drain, register readback.
// Define JEDRO_1_CHECK_MASK_EN to compare only the bits set in CHECK_MASKS.
module jedro_1_test_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_CHECKS     = 4,
    parameter int RST_CYCLES     = 3,
    parameter int MAX_CYCLES     = 32,
    parameter int DRAIN_CYCLES   = 3,
    parameter logic [NUM_CHECKS*REG_ADDR_WIDTH-1:0] CHECK_ADDRS  = '0,
    parameter logic [NUM_CHECKS*DATA_WIDTH-1:0]     CHECK_VALUES = '0,
    parameter logic [NUM_CHECKS*DATA_WIDTH-1:0]     CHECK_MASKS  = '1
) (
    input  logic                                                 clk_i,
    input  logic                                                 rstn_i,
    input  logic                                                 start_i,
    jedro_1_test_sequencer_if.master                             core_if,
    output logic                                                 done_o,
    output logic                                                 pass_o,
    output logic                                                 timeout_o,
    output logic [$clog2(MAX_CYCLES+1)-1:0]                      run_cycles_o,
    output logic [$clog2(NUM_CHECKS+1)-1:0]                      fail_cnt_o,
    output logic [((NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1)-1:0] first_fail_idx_o,
    output logic [DATA_WIDTH-1:0]                                first_fail_data_o
);
    localparam int RUN_W      = $clog2(MAX_CYCLES + 1);
    localparam int FC_W       = $clog2(NUM_CHECKS + 1);
    localparam int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int CNT_MAX_A  = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_A > NUM_CHECKS) ? CNT_MAX_A : NUM_CHECKS;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CORE_RST,
        S_RUN,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [RUN_W-1:0]          run_cnt_q, run_cnt_d;
    logic                      timeout_q, timeout_d;
    logic [FC_W-1:0]           fail_cnt_q, fail_cnt_d;
    logic [IDX_W-1:0]          ff_idx_q, ff_idx_d;
    logic [DATA_WIDTH-1:0]     ff_data_q, ff_data_d;
    logic                      done_q, done_d;
    logic                      pass_q, pass_d;
    logic                      core_rstn_q, core_rstn_d;
    logic [REG_ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                      clear_res;

    logic                      cmp_valid;
    logic [IDX_W-1:0]          cmp_idx;
    logic [DATA_WIDTH-1:0]     exp_val;
    logic                      mismatch;
`ifdef JEDRO_1_CHECK_MASK_EN
    logic [DATA_WIDTH-1:0]     exp_mask;
`else
    // Masks have no effect in this build; the reduction folds to a constant.
    logic                      unused_masks;
    assign unused_masks = ^CHECK_MASKS;
`endif

    // In CHECK cycle c (c >= 1) the read data belongs to entry c-1.
    always_comb begin
        cmp_valid = (state_q == S_CHECK) && (cnt_q != '0);
        cmp_idx   = '0;
        exp_val   = '0;
`ifdef JEDRO_1_CHECK_MASK_EN
        exp_mask  = '1;
`endif
        for (int k = 0; k < NUM_CHECKS; k++) begin
            if (cnt_q == CNT_W'(k + 1)) begin
                cmp_idx = IDX_W'(k);
                exp_val = CHECK_VALUES[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef JEDRO_1_CHECK_MASK_EN
                exp_mask = CHECK_MASKS[k*DATA_WIDTH +: DATA_WIDTH];
`endif
            end
        end
`ifdef JEDRO_1_CHECK_MASK_EN
        mismatch = ((core_if.rf_rdata_i & exp_mask) != (exp_val & exp_mask));
`else
        mismatch = (core_if.rf_rdata_i != exp_val);
`endif
    end

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_cnt_d  = run_cnt_q;
        timeout_d  = timeout_q;
        fail_cnt_d = fail_cnt_q;
        ff_idx_d   = ff_idx_q;
        ff_data_d  = ff_data_q;
        done_d     = done_q;
        pass_d     = pass_q;
        clear_res  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                clear_res = 1'b1;
                cnt_d     = '0;
                if (start_i) state_d = S_CORE_RST;
            end
            S_CORE_RST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                // A halt on the limit cycle is a normal end, not a timeout.
                if (core_if.halt_i || (run_cnt_d == RUN_W'(MAX_CYCLES))) begin
                    timeout_d = !core_if.halt_i;
                    state_d   = (DRAIN_CYCLES == 0) ? S_CHECK : S_DRAIN;
                    cnt_d     = '0;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_LAST)) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (cmp_valid && mismatch) begin
                    if (fail_cnt_q == '0) begin
                        ff_idx_d  = cmp_idx;
                        ff_data_d = core_if.rf_rdata_i;
                    end
                    fail_cnt_d = fail_cnt_q + 1'b1;
                end
                if (cnt_q == CNT_W'(NUM_CHECKS)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    pass_d  = !timeout_q && (fail_cnt_d == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    state_d   = S_CORE_RST;
                    clear_res = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_res) begin
            run_cnt_d  = '0;
            timeout_d  = 1'b0;
            fail_cnt_d = '0;
            ff_idx_d   = '0;
            ff_data_d  = '0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
        end

        // Core reset and read address come from flops so the core never sees decode glitches.
        core_rstn_d = (state_d != S_IDLE) && (state_d != S_CORE_RST);
        raddr_d     = '0;
        if (state_d == S_CHECK) begin
            for (int k = 0; k < NUM_CHECKS; k++) begin
                if (cnt_d == CNT_W'(k)) raddr_d = CHECK_ADDRS[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            end
        end
    end

    // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            run_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            fail_cnt_q  <= '0;
            ff_idx_q    <= '0;
            ff_data_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            core_rstn_q <= 1'b0;
            raddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_cnt_q   <= run_cnt_d;
            timeout_q   <= timeout_d;
            fail_cnt_q  <= fail_cnt_d;
            ff_idx_q    <= ff_idx_d;
            ff_data_q   <= ff_data_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            core_rstn_q <= core_rstn_d;
            raddr_q     <= raddr_d;
        end
    end

    assign core_if.core_rstn_o = core_rstn_q;
    assign core_if.rf_raddr_o  = raddr_q;
    assign done_o              = done_q;
    assign pass_o              = pass_q;
    assign timeout_o           = timeout_q;
    assign run_cycles_o        = run_cnt_q;
    assign fail_cnt_o          = fail_cnt_q;
    assign first_fail_idx_o    = ff_idx_q;
    assign first_fail_data_o   = ff_data_q;

endmodule
